// File: rtl/holy_core_pkg.sv
// Shared types and helpers for the holy core bus slaves.
// Holds AXI response codes, slave FSM state types and address-decode helpers.
package holy_core_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } slave_wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } slave_rd_state_t;

    // Widened to 33 bits so a window ending at the top of the map cannot wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span_bytes);
        logic [32:0] addr_w;
        logic [32:0] base_w;
        addr_w = {1'b0, addr};
        base_w = {1'b0, base};
        return (addr_w >= base_w) && (addr_w < (base_w + span_bytes));
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/holy_bram_be.sv
// Simple dual-port RAM: byte-enable write port, registered read-first read port.
// The read register can be forced to zero so out-of-range reads return clean data.
module holy_bram_be #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic             rclr,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rd_data_r;

    // Byte-lane writes; contents deliberately have no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register samples the old word when a write hits the same address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r <= 32'h0000_0000;
        end else if (re) begin
            if (rclr) begin
                rd_data_r <= 32'h0000_0000;
            end else begin
                rd_data_r <= mem_r[raddr];
            end
        end
    end

    assign rdata = rd_data_r;

endmodule

// File: rtl/holy_axi_lite_slave_mem.sv
// AXI-Lite slave in front of a byte-writable word RAM, with optional wait states.
// Write and read FSMs are independent; each allows one outstanding transaction.
module holy_axi_lite_slave_mem
    import holy_core_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT_C      = 4'(LATENCY);

    slave_wr_state_t  w_state_r, w_state_nxt_s;
    logic             aw_held_r, w_held_r, aw_held_nxt_s, w_held_nxt_s;
    logic [31:0]      awaddr_r, wdata_r;
    logic [3:0]       wstrb_r;
    logic [3:0]       w_cnt_r, w_cnt_nxt_s;
    logic             awready_r, wready_r, bvalid_r;
    logic [1:0]       bresp_r;
    logic             awready_nxt_s, wready_nxt_s, bvalid_nxt_s;
    logic [1:0]       bresp_nxt_s;
    logic             aw_hs_s, w_hs_s, b_hs_s, w_commit_s;
    logic [31:0]      wr_addr_s, wr_data_s, wr_off_s;
    logic [3:0]       wr_strb_s, mem_we_s;
    logic             wr_in_range_s;
    logic [IDX_W-1:0] wr_idx_s;

    slave_rd_state_t  r_state_r, r_state_nxt_s;
    logic [31:0]      araddr_r;
    logic [3:0]       r_cnt_r, r_cnt_nxt_s;
    logic             arready_r, rvalid_r;
    logic [1:0]       rresp_r;
    logic             arready_nxt_s, rvalid_nxt_s;
    logic [1:0]       rresp_nxt_s;
    logic             ar_hs_s, r_hs_s, rd_sample_s;
    logic [31:0]      rd_addr_s, rd_off_s;
    logic             rd_in_range_s;
    logic [IDX_W-1:0] rd_idx_s;

    assign aw_hs_s = awvalid & awready_r;
    assign w_hs_s  = wvalid & wready_r;
    assign b_hs_s  = bvalid_r & bready;
    assign ar_hs_s = arvalid & arready_r;
    assign r_hs_s  = rvalid_r & rready;

    // Commit operands: take the live bus value when its handshake lands this cycle.
    always_comb begin
        if (aw_held_r) begin
            wr_addr_s = awaddr_r;
        end else begin
            wr_addr_s = awaddr;
        end
        if (w_held_r) begin
            wr_data_s = wdata_r;
            wr_strb_s = wstrb_r;
        end else begin
            wr_data_s = wdata;
            wr_strb_s = wstrb;
        end
        if (r_state_r == R_IDLE) begin
            rd_addr_s = araddr;
        end else begin
            rd_addr_s = araddr_r;
        end
    end

    assign wr_in_range_s = addr_in_range(wr_addr_s, BASE_ADDR, SPAN_BYTES);
    assign wr_off_s      = addr_offset(wr_addr_s, BASE_ADDR);
    assign wr_idx_s      = IDX_W'(wr_off_s >> 2);
    assign rd_in_range_s = addr_in_range(rd_addr_s, BASE_ADDR, SPAN_BYTES);
    assign rd_off_s      = addr_offset(rd_addr_s, BASE_ADDR);
    assign rd_idx_s      = IDX_W'(rd_off_s >> 2);

    // Write FSM next state.
    always_comb begin
        w_state_nxt_s = w_state_r;
        w_cnt_nxt_s   = w_cnt_r;
        aw_held_nxt_s = aw_held_r | aw_hs_s;
        w_held_nxt_s  = w_held_r | w_hs_s;
        w_commit_s    = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (aw_held_nxt_s && w_held_nxt_s) begin
                    if (LAT_C == 4'd0) begin
                        w_state_nxt_s = W_RESP;
                        w_commit_s    = 1'b1;
                    end else begin
                        w_state_nxt_s = W_WAIT;
                        w_cnt_nxt_s   = LAT_C;
                    end
                end else begin
                    w_state_nxt_s = W_IDLE;
                end
            end
            W_WAIT: begin
                if (w_cnt_r <= 4'd1) begin
                    w_state_nxt_s = W_RESP;
                    w_commit_s    = 1'b1;
                end else begin
                    w_cnt_nxt_s = w_cnt_r - 4'd1;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    w_state_nxt_s = W_IDLE;
                    aw_held_nxt_s = 1'b0;
                    w_held_nxt_s  = 1'b0;
                end else begin
                    w_state_nxt_s = W_RESP;
                end
            end
            default: begin
                w_state_nxt_s = W_IDLE;
                aw_held_nxt_s = 1'b0;
                w_held_nxt_s  = 1'b0;
            end
        endcase
    end

    // Write channel outputs, registered one cycle later from the next state.
    always_comb begin
        awready_nxt_s = (w_state_nxt_s == W_IDLE) && !aw_held_nxt_s;
        wready_nxt_s  = (w_state_nxt_s == W_IDLE) && !w_held_nxt_s;
        bvalid_nxt_s  = (w_state_nxt_s == W_RESP);
        if (w_commit_s && rst_n) begin
            bresp_nxt_s = wr_in_range_s ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            mem_we_s    = wr_in_range_s ? wr_strb_s : 4'b0000;
        end else begin
            bresp_nxt_s = bresp_r;
            mem_we_s    = 4'b0000;
        end
    end

    // Write FSM state and channel registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            w_cnt_r   <= 4'd0;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awaddr_r  <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'b0000;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
        end else begin
            w_state_r <= w_state_nxt_s;
            w_cnt_r   <= w_cnt_nxt_s;
            aw_held_r <= aw_held_nxt_s;
            w_held_r  <= w_held_nxt_s;
            if (aw_hs_s) begin
                awaddr_r <= awaddr;
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
            awready_r <= awready_nxt_s;
            wready_r  <= wready_nxt_s;
            bvalid_r  <= bvalid_nxt_s;
            bresp_r   <= bresp_nxt_s;
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_nxt_s = r_state_r;
        r_cnt_nxt_s   = r_cnt_r;
        rd_sample_s   = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    if (LAT_C == 4'd0) begin
                        r_state_nxt_s = R_RESP;
                        rd_sample_s   = 1'b1;
                    end else begin
                        r_state_nxt_s = R_WAIT;
                        r_cnt_nxt_s   = LAT_C;
                    end
                end else begin
                    r_state_nxt_s = R_IDLE;
                end
            end
            R_WAIT: begin
                if (r_cnt_r <= 4'd1) begin
                    r_state_nxt_s = R_RESP;
                    rd_sample_s   = 1'b1;
                end else begin
                    r_cnt_nxt_s = r_cnt_r - 4'd1;
                end
            end
            R_RESP: begin
                if (r_hs_s) begin
                    r_state_nxt_s = R_IDLE;
                end else begin
                    r_state_nxt_s = R_RESP;
                end
            end
            default: begin
                r_state_nxt_s = R_IDLE;
            end
        endcase
    end

    // Read channel outputs.
    always_comb begin
        arready_nxt_s = (r_state_nxt_s == R_IDLE);
        rvalid_nxt_s  = (r_state_nxt_s == R_RESP);
        if (rd_sample_s) begin
            rresp_nxt_s = rd_in_range_s ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end else begin
            rresp_nxt_s = rresp_r;
        end
    end

    // Read FSM state and channel registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            r_cnt_r   <= 4'd0;
            araddr_r  <= 32'h0000_0000;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rresp_r   <= 2'b00;
        end else begin
            r_state_r <= r_state_nxt_s;
            r_cnt_r   <= r_cnt_nxt_s;
            if (ar_hs_s) begin
                araddr_r <= araddr;
            end
            arready_r <= arready_nxt_s;
            rvalid_r  <= rvalid_nxt_s;
            rresp_r   <= rresp_nxt_s;
        end
    end

    holy_bram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we_s),
        .waddr (wr_idx_s),
        .wdata (wr_data_s),
        .re    (rd_sample_s),
        .rclr  (!rd_in_range_s),
        .raddr (rd_idx_s),
        .rdata (rdata)
    );

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rresp   = rresp_r;

endmodule

// File: tb/tb_holy_axi_lite_slave_mem.sv
// Bench for holy_axi_lite_slave_mem: two instances (LATENCY 0 at base 0, LATENCY 3 at
// base 0x8000_0000) driven by directed and random transactions against a word-array model.
module tb_holy_axi_lite_slave_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [2];
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [2][1024];

    holy_axi_lite_slave_mem #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
        .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]),
        .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]));

    holy_axi_lite_slave_mem #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
        .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]),
        .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'h8000_0000;
    endfunction

    function automatic bit in_rng(input int d, input logic [31:0] addr);
        logic [63:0] a;
        logic [63:0] b;
        a = {32'h0, addr};
        b = {32'h0, base_of(d)};
        return (a >= b) && (a < b + 64'd4096);
    endfunction

    function automatic int idx_of(input int d, input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - base_of(d)) >> 2;
        return int'(off);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Full write transaction; starts and ends on a falling edge with channels idle.
    task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly);
        bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs, rdy_bad = 1'b0, hold_bad = 1'b0;
        int c = 0, wait_n = 0;
        logic [1:0] resp0, exp_resp;
        int ix;
        awaddr[d] = addr; wdata[d] = data; wstrb[d] = strb; bready[d] = 1'b0;
        while (!(aw_done && w_done) && c < 100) begin
            awvalid[d] = !aw_done && (c >= aw_dly);
            wvalid[d]  = !w_done && (c >= w_dly);
            aw_hs = awvalid[d] & awready[d];
            w_hs  = wvalid[d] & wready[d];
            @(posedge clk);
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
            @(negedge clk);
            c++;
            if ((aw_done && awready[d]) || (w_done && wready[d])) rdy_bad = 1'b1;
        end
        awvalid[d] = 1'b0; wvalid[d] = 1'b0;
        check("aw_w_accepted", 32'(aw_done && w_done), 32'd1);
        while (!bvalid[d] && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
            if (awready[d] || wready[d]) rdy_bad = 1'b1;
        end
        check("b_latency", 32'(wait_n), 32'(lat_of(d)));
        resp0 = bresp[d];
        repeat (b_dly) begin
            @(negedge clk);
            if (!bvalid[d] || bresp[d] !== resp0 || awready[d] || wready[d]) hold_bad = 1'b1;
        end
        bready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready[d] = 1'b0;
        exp_resp = in_rng(d, addr) ? 2'b00 : 2'b10;
        check("bresp", 32'(resp0), 32'(exp_resp));
        check("b_hold", 32'(hold_bad), 32'd0);
        check("w_ready_low", 32'(rdy_bad), 32'd0);
        check("b_after_hs", 32'({bvalid[d], awready[d], wready[d]}), 32'b011);
        if (in_rng(d, addr)) begin
            ix = idx_of(d, addr);
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) mdl[d][ix][8*i +: 8] = data[8*i +: 8];
            end
        end
    endtask

    // Full read transaction; returns the observed data.
    task automatic do_read(input int d, input logic [31:0] addr, input int r_dly,
                           output logic [31:0] got);
        bit done = 1'b0, rdy_bad = 1'b0, hold_bad = 1'b0;
        int c = 0, wait_n = 0;
        logic [1:0] resp0;
        logic [31:0] exp_data;
        araddr[d] = addr; rready[d] = 1'b0;
        while (!done && c < 100) begin
            arvalid[d] = 1'b1;
            done = arready[d];
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        arvalid[d] = 1'b0;
        check("ar_accepted", 32'(done), 32'd1);
        if (arready[d]) rdy_bad = 1'b1;
        while (!rvalid[d] && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
            if (arready[d]) rdy_bad = 1'b1;
        end
        check("r_latency", 32'(wait_n), 32'(lat_of(d)));
        resp0 = rresp[d];
        got   = rdata[d];
        repeat (r_dly) begin
            @(negedge clk);
            if (!rvalid[d] || rresp[d] !== resp0 || rdata[d] !== got || arready[d]) hold_bad = 1'b1;
        end
        rready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready[d] = 1'b0;
        exp_data = in_rng(d, addr) ? mdl[d][idx_of(d, addr)] : 32'h0;
        check("rresp", 32'(resp0), in_rng(d, addr) ? 32'd0 : 32'd2);
        check("rdata", got, exp_data);
        check("r_hold", 32'(hold_bad), 32'd0);
        check("ar_ready_low", 32'(rdy_bad), 32'd0);
        check("r_after_hs", 32'({rvalid[d], arready[d]}), 32'b01);
    endtask

    function automatic logic [31:0] rand_addr(input int d);
        int w;
        logic [31:0] lo;
        lo = 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 2))
                0:       return base_of(d) + 32'h0000_1000 + lo;
                1:       return base_of(d) - 32'd4 + lo;
                default: return 32'hFFFF_FFFC;
            endcase
        end
        w = $urandom_range(0, 19);
        if (w >= 16) w = w + 1004;
        return base_of(d) + 32'(w * 4) + lo;
    endfunction

    initial begin
        logic [31:0] got, old;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; awvalid[d] = 1'b0; wvalid[d] = 1'b0; arvalid[d] = 1'b0;
            bready[d] = 1'b0; rready[d] = 1'b0; awaddr[d] = 32'h0; araddr[d] = 32'h0;
            wdata[d] = 32'h0; wstrb[d] = 4'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_outputs", {awready[d], wready[d], arready[d], bvalid[d], rvalid[d],
                                    bresp[d], rresp[d], 23'h0} | rdata[d], 32'h0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("ready_after_reset", 32'({awready[d], wready[d], arready[d]}), 32'b111);
        end

        // Give every word the random phase touches a known value.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 20; w++) begin
                do_write(d, base_of(d) + 32'(((w >= 16) ? w + 1004 : w) * 4), $urandom(),
                         4'hF, 0, 0, 0);
            end
        end

        do_write(0, 32'h10, 32'hCAFE_BABE, 4'hF, 0, 0, 0);
        do_read(0, 32'h10, 0, got);
        check("basic_readback", got, 32'hCAFE_BABE);
        do_write(0, 32'h10, 32'h1122_3344, 4'b0101, 3, 0, 0);
        do_read(0, 32'h10, 0, got);
        check("lane_readback", got, 32'hCA22_BA44);

        do_read(0, 32'h0, 0, old);
        do_write(0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(0, 32'h0000_1000, 0, got);
        do_read(0, 32'h0, 0, got);
        check("oor_no_alias", got, old);
        do_write(1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 1, 0, 0);
        do_write(0, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
        do_read(0, 32'h20, 0, got);

        do_write(1, 32'h8000_0020, 32'hA5A5_0F0F, 4'hF, 0, 2, 5);
        do_read(1, 32'h8000_0020, 5, got);
        do_read(1, 32'h8000_0FFC, 2, got);

        // Read and write of the same word land on one edge.
        old = mdl[0][8];
        awaddr[0] = 32'h20; wdata[0] = 32'h55; wstrb[0] = 4'hF; araddr[0] = 32'h20;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1; arvalid[0] = 1'b1;
        bready[0] = 1'b1; rready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
        check("collide_valids", 32'({bvalid[0], rvalid[0]}), 32'b11);
        check("collide_old_data", rdata[0], old);
        @(posedge clk);
        @(negedge clk);
        bready[0] = 1'b0; rready[0] = 1'b0;
        mdl[0][8] = 32'h55;
        do_read(0, 32'h20, 0, got);
        check("collide_new_data", got, 32'h55);

        // Reset while the LATENCY=3 write sits in W_WAIT.
        awaddr[1] = 32'h8000_0014; wdata[1] = 32'h0BAD_F00D; wstrb[1] = 4'hF;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid[1] = 1'b0; wvalid[1] = 1'b0; rst_n[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_no_bvalid", 32'(bvalid[1]), 32'd0);
        end
        rst_n[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_pulse", 32'({awready[1], wready[1], arready[1]}), 32'b111);
        repeat (5) @(negedge clk);
        check("no_late_bvalid", 32'(bvalid[1]), 32'd0);
        do_read(1, 32'h8000_0014, 0, got);

        for (int n = 0; n < 120; n++) begin
            int d;
            logic [31:0] a;
            d = n % 2;
            a = rand_addr(d);
            if ($urandom_range(0, 1) == 1) begin
                do_write(d, a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                do_read(d, a, $urandom_range(0, 3), got);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/holy_axi_lite_slave_mem.md
Name: holy_axi_lite_slave_mem

Overview:
AXI-Lite slave (responder) that fronts a word-addressed, byte-writable RAM. It is the memory the uncached data path and instruction fetch talk to in the SoC and in simulation benches. AW, W and AR channels are accepted independently. Optional wait states stretch responses so that master stall paths get exercised.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of word 0
DEPTH_WORDS, 1024, number of 32-bit words (power of two)
LATENCY, 0, extra wait cycles before bvalid/rvalid (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset
awaddr  in  32  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  32  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk.
- While rst_n=0: awready, wready, arready, bvalid and rvalid are 0; bresp=rresp=2'b00; rdata=0; both FSMs go to IDLE.
- Memory contents are not reset.
- Reset asserted mid-transaction abandons it: no response is issued, and a write that has not committed is not performed.
- Address decode:
  - word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS, computed in 33-bit arithmetic so there is no wrap past 32'hFFFF_FFFF.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: awready = ~aw_held; wready = ~w_held.
  - An AW handshake latches awaddr and sets aw_held. A W handshake latches wdata/wstrb and sets w_held. The two may complete in the same cycle or in either order.
  - When aw_held & w_held: go to W_WAIT with counter = LATENCY. With LATENCY=0, W_WAIT lasts zero cycles.
  - Commit on exit to W_RESP:
    - in range: each byte lane with wstrb[i]=1 is written; wstrb=0 writes nothing but still returns OKAY; bresp=2'b00.
    - out of range: no write; bresp=2'b10 (SLVERR).
  - W_RESP: bvalid=1, awready=wready=0. bvalid and bresp are held stable until bready. On the handshake, clear the held flags and return to W_IDLE.
  - Timing: with LATENCY=0, bvalid rises 1 cycle after the later of the AW/W handshakes. LATENCY=N adds N cycles.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. An AR handshake latches araddr and moves to R_WAIT with counter = LATENCY.
  - Exit to R_RESP registers rdata = mem[index] and rresp = 2'b00 if in range. Out of range gives rdata = 32'h0 and rresp = 2'b10.
  - R_RESP: rvalid=1, arready=0. rdata and rresp are held stable until rready; on the handshake return to R_IDLE.
  - Timing: with LATENCY=0, rvalid rises 1 cycle after the AR handshake.
- Concurrency:
  - Read and write FSMs run fully in parallel.
  - If a write commit and a read sample hit the same word on the same edge, the read returns the pre-write data.
- Outstanding depth is exactly one per direction; no interleaving.
- A valid held by the master while ready=0 is simply not accepted. There is no combinational path from any valid to any ready.

Decomposition:
- holy_core_pkg gains:
  - AXI_RESP_OKAY = 2'b00 and AXI_RESP_SLVERR = 2'b10.
  - typedef slave_wr_state_t {W_IDLE, W_WAIT, W_RESP}.
  - typedef slave_rd_state_t {R_IDLE, R_WAIT, R_RESP}.
- Sub-module holy_bram_be: 1 write port and 1 read port, byte-enable write, registered read-first output, parameter DEPTH_WORDS. It is instantiated once so that FPGA BRAM inference is isolated from the protocol logic.

Test Plan:
- LATENCY=0; AW 0x10 and W 0xCAFEBABE with wstrb 4'hF in the same cycle, bready=1 → bvalid 1 cycle later, bresp 00. Then AR 0x10 → rvalid next cycle, rdata 0xCAFEBABE, rresp 00.
- W before AW: W (0x11223344, strb 4'b0101) at cycle 0, AW 0x10 at cycle 3 → bvalid at cycle 4. Readback gives 0xCA22BA44, confirming only lanes 0 and 2 were written.
- Out of range: AW/AR 0x0000_1000 with DEPTH=1024, BASE=0 → bresp 10 and memory unchanged; rresp 10 and rdata 0.
- Backpressure with LATENCY=3: bready and rready held 0 for 5 cycles → responses appear after 3 wait cycles and stay stable. awready, wready and arready stay 0 until the respective handshake.
- Same-edge collision: a read of address A sampled on the same edge as a write of 0x55 to A → rdata returns the old value; the next read returns 0x55.
- Reset pulse while in W_WAIT → no bvalid, target word unchanged; awready, wready and arready are 1 the cycle after rst_n rises.
